// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM state encodings
// and requester IDs used to remember which master was served last.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational next-owner selection: round-robin on contention from IDLE,
// handover when the owner lets go, and hold-limit preemption unless locked.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  arb_state_t state,
  input  logic       hold_full,
  input  logic       lock0,
  input  logic       lock1,
  output arb_state_t next_state
);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          next_state = (last == REQ_CPU) ? ST_OWN1 : ST_OWN0;
        end else if (req0) begin
          next_state = ST_OWN0;
        end else if (req1) begin
          next_state = ST_OWN1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!req0) begin
          next_state = req1 ? ST_OWN1 : ST_IDLE;
        end else if (hold_full && req1 && !lock0) begin
          next_state = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          next_state = req0 ? ST_OWN0 : ST_IDLE;
        end else if (hold_full && req0 && !lock1) begin
          next_state = ST_OWN0;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the CPU and a secondary master shared access to
// a single-port memory, with bounded hold time, burst lock and read return.
//
// state   | meaning
// IDLE    | no owner; memory port shows master 0 inputs, no write strobe
// OWN0    | master 0 (CPU) granted; one transfer per cycle while req0 high
// OWN1    | master 1 (DMA/debug) granted; one transfer per cycle while req1 high
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int MAX_HOLD  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t          state;
  arb_state_t          next_state;
  logic                last;
  logic [HW-1:0]       hold_cnt;
  logic                hold_full;
  logic                sel1;
  logic                acc0;
  logic                acc1;
  logic                accepted;
  logic                we_own;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic                rv0_q;
  logic                rv1_q;

  assign gnt0 = (state == ST_OWN0);
  assign gnt1 = (state == ST_OWN1);
  assign busy = gnt0 | gnt1;

  // Nothing is accepted while rst is high so no write can slip out during reset.
  assign acc0     = gnt0 && req0 && !rst;
  assign acc1     = gnt1 && req1 && !rst;
  assign accepted = acc0 | acc1;

  assign sel1      = gnt1;
  assign sel_addr  = sel1 ? addr1 : addr0;
  assign we_own    = sel1 ? we1 : we0;
  assign mem_addr  = {sel_addr[ADDR_SIZE-1:1], 1'b0};
  assign mem_wdata = sel1 ? wdata1 : wdata0;
  assign mem_we    = accepted && we_own;

  assign hold_full = (hold_cnt == HW'(MAX_HOLD));

  rr_pick u_rr_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .state     (state),
    .hold_full (hold_full),
    .lock0     (lock0),
    .lock1     (lock1),
    .next_state(next_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= REQ_DMA;
      hold_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        hold_cnt <= '0;
        if (next_state == ST_OWN0) last <= REQ_CPU;
        if (next_state == ST_OWN1) last <= REQ_DMA;
      end else if (accepted && !hold_full) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rdata <= '0;
    end else begin
      rv0_q <= acc0 && !we0;
      rv1_q <= acc1 && !we1;
      rdata <= mem_rdata;
    end
  end

  // A read returning in a reset cycle is dropped rather than presented.
  assign rvalid0 = rv0_q && !rst;
  assign rvalid1 = rv1_q && !rst;

endmodule
